fp_div_seq: RTL

Sequential floating-point divider computing q = a / b as a × recip(b). It sits directly downstream of the `reciprocal` unit, which it instantiates combinationally on the latched divisor. It consumes that unit's significand and `recipFlags`, then performs an iterative shift-add significand multiply, normalization and round-to-nearest-even. Operands and results use valid/ready handshakes at the FPU operand bus.

---
 rtl/fp_div_seq.sv | 298 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_div_seq.sv
// Sequential floating-point divider: q = a * recip(b), shift-add significand
// multiply, normalize, round-to-nearest-even. Default word is bf16.
// Optional feature macro: FPU_DIV_STICKY_FLAGS_EN adds flags_clr / sticky_flags.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and outputs are held while valid && !ready.

// Field decoder; subnormals are normalized so sig_o always has its leading one
// at bit NSIG (except for zero) and exp_o is the matching unbiased-by-field exponent.
module fp_unpack #(
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input  logic [NEXP+NSIG:0]      x_i,
  output logic [NSIG:0]           sig_o,
  output logic signed [NEXP+1:0]  exp_o,
  output logic                    zero_o,
  output logic                    inf_o,
  output logic                    nan_o,
  output logic                    snan_o
);
  logic [NEXP-1:0] e;
  logic [NSIG-1:0] f;
  logic [NEXP+1:0] shift;

  assign e = x_i[NEXP+NSIG-1:NSIG];
  assign f = x_i[NSIG-1:0];

  // Shift that moves the top set fraction bit up to the hidden-bit position.
  always_comb begin
    shift = '0;
    for (int i = 0; i < NSIG; i++)
      if (f[i]) shift = (NEXP+2)'(NSIG - i);
  end

  // Significand and exponent, with subnormal normalization (ea = 1 - shift).
  always_comb begin
    if (e != '0) begin
      sig_o = {1'b1, f};
      exp_o = signed'({2'b00, e});
    end else begin
      sig_o = {1'b0, f} << shift;
      exp_o = signed'((NEXP+2)'(1) - shift);
    end
  end

  assign zero_o = (e == '0) && (f == '0);
  assign inf_o  = (&e) && (f == '0);
  assign nan_o  = (&e) && (f != '0);
  assign snan_o = nan_o && !f[NSIG-1];
endmodule

// Combinational reciprocal of the divisor. Significand is truncated 2/m.
// recip_flags_o: 0 INFINITY (1/b overflows, incl. b=0), 1 b zero,
// 2 b infinite (1/b is zero), 3 b NaN, 4 b signalling NaN.
module reciprocal #(
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input  logic [NEXP+NSIG:0]      b_i,
  output logic [NSIG:0]           sig_o,
  output logic signed [NEXP+1:0]  exp_o,
  output logic [4:0]              recip_flags_o
);
  localparam int PW = 2*NSIG + 2;
  localparam logic [PW-1:0]          TWO_SCALED = PW'(1) << (2*NSIG + 1);
  localparam logic signed [NEXP+1:0] TWO_BIAS   = (NEXP+2)'(2*(2**(NEXP-1) - 1));
  localparam logic signed [NEXP+1:0] ONE_S      = (NEXP+2)'(1);
  localparam logic signed [NEXP+1:0] EXP_INF    = (NEXP+2)'(2**NEXP - 1);

  logic [NSIG:0]          bsig;
  logic signed [NEXP+1:0] bexp;
  logic bzero, binf, bnan, bsnan;

  fp_unpack #(.NEXP(NEXP), .NSIG(NSIG)) u_unpack (
    .x_i(b_i), .sig_o(bsig), .exp_o(bexp),
    .zero_o(bzero), .inf_o(binf), .nan_o(bnan), .snan_o(bsnan)
  );

  // A power-of-two divisor has an exact reciprocal; otherwise 1/m lies in
  // (0.5,1) so it is doubled into [1,2) and the exponent drops by one.
  always_comb begin
    if (bsig[NSIG-1:0] == '0) begin
      sig_o = {1'b1, {NSIG{1'b0}}};
      exp_o = TWO_BIAS - bexp;
    end else begin
      sig_o = (NSIG+1)'(TWO_SCALED / PW'(bsig));
      exp_o = TWO_BIAS - bexp - ONE_S;
    end
  end

  assign recip_flags_o = {bsnan, bnan, binf, bzero,
                          bzero || (!binf && !bnan && (exp_o >= EXP_INF))};
endmodule

module fp_div_seq #(
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NEXP+NSIG:0]   a,
  input  logic [NEXP+NSIG:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NEXP+NSIG:0]   q,
  output logic [4:0]           except_flags,
`ifdef FPU_DIV_STICKY_FLAGS_EN
  input  logic                 flags_clr,
  output logic [4:0]           sticky_flags,
`endif
  output logic [1:0]           dbg_state_o
);
  localparam int DW = NEXP + NSIG + 1;
  localparam int W  = NSIG + 1;
  localparam int PW = 2*W;
  localparam int EW = NEXP + 2;
  localparam int CW = $clog2(NSIG + 2) + 1;
  localparam logic [CW-1:0]        CNT_SETUP = CW'(NSIG + 1);
  localparam logic [CW-1:0]        CNT_MUL   = CW'(NSIG);
  localparam logic signed [EW-1:0] BIAS_S    = EW'(2**(NEXP-1) - 1);
  localparam logic signed [EW-1:0] EXP_INF   = EW'(2**NEXP - 1);
  localparam logic signed [EW-1:0] ONE_S     = EW'(1);
  localparam logic [4:0] F_INV = 5'b00001, F_DZ = 5'b00010, F_OVF = 5'b00100,
                         F_UNF = 5'b01000, F_INX = 5'b10000;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         a_q, a_d, b_q, b_d, q_q, q_d;
  logic                  sign_q, sign_d;
  logic signed [EW-1:0]  exp_q, exp_d;
  logic [PW-1:0]         mcand_q, mcand_d, acc_q, acc_d;
  logic [W-1:0]          mplier_q, mplier_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4:0]            flags_q, flags_d;

  logic [W-1:0]          a_sig, r_sig;
  logic signed [EW-1:0]  a_exp, r_exp, e_adj, e_fin;
  logic                  a_zero, a_inf, a_nan, a_snan, sign_new;
  logic [4:0]            rflags;
  logic [PW-1:0]         pn;
  logic [W:0]            rnd_sum;
  logic [NSIG-1:0]       frac;
  logic                  norm_inc, guard, sticky, round_up, carry;

  fp_unpack #(.NEXP(NEXP), .NSIG(NSIG)) u_unpack_a (
    .x_i(a_q), .sig_o(a_sig), .exp_o(a_exp),
    .zero_o(a_zero), .inf_o(a_inf), .nan_o(a_nan), .snan_o(a_snan)
  );

  reciprocal #(.NEXP(NEXP), .NSIG(NSIG)) u_recip (
    .b_i(b_q), .sig_o(r_sig), .exp_o(r_exp), .recip_flags_o(rflags)
  );

  assign sign_new = a_q[DW-1] ^ b_q[DW-1];

  // Normalize the product, round to nearest even, and form the final exponent.
  always_comb begin
    norm_inc = acc_q[PW-1];
    pn       = norm_inc ? acc_q : (acc_q << 1);
    guard    = pn[NSIG];
    sticky   = |pn[NSIG-1:0];
    round_up = guard && (sticky || pn[NSIG+1]);
    rnd_sum  = {1'b0, pn[PW-1:NSIG+1]} + (W+1)'(round_up);
    carry    = rnd_sum[W];
    frac     = carry ? rnd_sum[NSIG:1] : rnd_sum[NSIG-1:0];
    e_adj    = {{(EW-2){1'b0}}, {1'b0, norm_inc} + {1'b0, carry}};
    e_fin    = exp_q + e_adj;
  end

  // Next-state logic: operand capture, special cases, multiply steps, rounding.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    q_d      = q_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = CNT_SETUP;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (cnt_q == CNT_SETUP) begin
          // First MUL cycle: the reciprocal of the latched divisor is now valid.
          sign_d  = sign_new;
          state_d = S_DONE;
          flags_d = '0;
          if (a_nan || rflags[3]) begin
            q_d     = {sign_new, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
            flags_d = (a_snan || rflags[4]) ? F_INV : 5'b0;
          end else if ((a_zero && rflags[1]) || (a_inf && rflags[2])) begin
            q_d     = {sign_new, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
            flags_d = F_INV;
          end else if (rflags[1]) begin
            q_d     = {sign_new, {NEXP{1'b1}}, {NSIG{1'b0}}};
            flags_d = F_DZ;
          end else if (a_inf) begin
            q_d     = {sign_new, {NEXP{1'b1}}, {NSIG{1'b0}}};
          end else if (a_zero || rflags[2]) begin
            q_d     = {sign_new, {(DW-1){1'b0}}};
          end else if (rflags[0]) begin
            q_d     = {sign_new, {NEXP{1'b1}}, {NSIG{1'b0}}};
            flags_d = F_OVF | F_INX;
          end else begin
            mcand_d  = PW'(a_sig);
            mplier_d = r_sig;
            acc_d    = '0;
            exp_d    = a_exp + r_exp - BIAS_S;
            cnt_d    = CNT_MUL;
            state_d  = S_MUL;
          end
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (cnt_q == '0) state_d = S_NORM;
          else             cnt_d   = cnt_q - CW'(1);
        end
      end
      S_NORM: begin
        state_d = S_DONE;
        if (e_fin >= EXP_INF) begin
          q_d     = {sign_q, {NEXP{1'b1}}, {NSIG{1'b0}}};
          flags_d = F_OVF | F_INX;
        end else if (e_fin < ONE_S) begin
          q_d     = {sign_q, {(DW-1){1'b0}}};
          flags_d = F_UNF | F_INX;
        end else begin
          q_d     = {sign_q, e_fin[NEXP-1:0], frac};
          flags_d = (guard || sticky) ? F_INX : 5'b0;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      q_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      q_q      <= q_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      flags_q  <= flags_d;
    end
  end

`ifdef FPU_DIV_STICKY_FLAGS_EN
  logic [4:0] sticky_q;
  // Accumulate result flags per output handshake; clear has priority.
  always_ff @(posedge clk) begin
    if (!rst_n)                               sticky_q <= '0;
    else if (flags_clr)                       sticky_q <= '0;
    else if ((state_q == S_DONE) && out_ready) sticky_q <= sticky_q | flags_q;
  end
  assign sticky_flags = sticky_q;
`endif

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign q            = q_q;
  assign except_flags = flags_q;
  assign dbg_state_o  = state_q;
endmodule
